uart_tx_mmio: RTL

//   Memory-mapped UART transmitter: the CPU-facing responder that drives ftdi_txd.
//   CPU writes a byte, it enters a FIFO, and a shift FSM serialises 8N1 frames at a

---
 rtl/uart_tx_mmio.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a small FIFO, a shift FSM
// serialises them onto tx, and reads return {overflow, full, busy}.
module uart_tx_mmio #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_wstrb,
  input  logic [31:0] io_wdata,
  input  logic        io_rstrb,
  output logic [31:0] io_rdata,
  output logic        tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int PW           = $clog2(FIFO_DEPTH);
  localparam int CNTW         = PW + 1;
  localparam logic [CW-1:0]   BAUD_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] DEPTH     = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0] count_reg;
  logic            overflow_reg;
  logic [31:0]     rdata_reg;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg;
  logic            tx_reg, tx_next;

  logic full, empty, busy, push, pop, shift_en;
  logic wdata_unused;

  assign wdata_unused = ^io_wdata[31:8];

  assign full  = (count_reg == DEPTH);
  assign empty = (count_reg == '0);
  assign busy  = (state_reg != IDLE) || !empty;
  // Full is judged before this edge's pop, so a write racing a pop into a full FIFO is dropped.
  assign push  = io_wstrb && !full;

  assign io_rdata = rdata_reg;
  assign tx       = tx_reg;

  // FIFO bookkeeping and CPU status register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + CNTW'(1);
        2'b01:   count_reg <= count_reg - CNTW'(1);
        default: count_reg <= count_reg;
      endcase
      if (io_wstrb && full)
        overflow_reg <= 1'b1;
      else if (io_rstrb)
        overflow_reg <= 1'b0;
      if (io_rstrb)
        rdata_reg <= {29'b0, overflow_reg, full, busy};
    end
  end

  // Storage array and shift register carry no reset; the pointers and FSM define validity.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= io_wdata[7:0];
    if (pop)
      shift_reg <= fifo_mem[rd_ptr_reg];
    else if (shift_en)
      shift_reg <= {1'b0, shift_reg[7:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    pop        = 1'b0;
    shift_en   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          cnt_next   = BAUD_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (cnt_reg == '0) begin
          cnt_next   = BAUD_LOAD;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == '0) begin
          cnt_next = BAUD_LOAD;
          shift_en = 1'b1;
          if (bit_reg == 3'd7)
            state_next = STOP;
          else
            bit_next = bit_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      STOP: begin
        if (cnt_reg == '0) begin
          // Back-to-back frames: a waiting byte goes straight into its start bit.
          if (!empty) begin
            pop        = 1'b1;
            cnt_next   = BAUD_LOAD;
            state_next = START;
          end else begin
            cnt_next   = '0;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    unique case (state_reg)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

endmodule
